// File: rtl/snow64_memory_bus_guard.sv
// Single-outstanding memory bus guard: round-robin arbitration between the read
// and write access FIFOs, one command in flight, completion routed back to the issuer.
module snow64_memory_bus_guard #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_cmd_accepted_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_cmd_accepted_o,
  output logic                  wr_valid_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_busy_i,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {Idle, WaitRd, WaitWr} state_e;

  state_e                state_q;
  logic                  last_grant_wr_q;
  logic                  rd_cmd_accepted_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_cmd_accepted_q;
  logic                  wr_valid_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic grant_rd_d;
  logic grant_any_d;

  // Read wins when alone, or when both request and the write went last.
  assign grant_rd_d  = rd_req_i & (~wr_req_i | last_grant_wr_q);
  assign grant_any_d = (rd_req_i | wr_req_i) & ~mem_busy_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= Idle;
      last_grant_wr_q   <= 1'b1;
      rd_cmd_accepted_q <= 1'b0;
      rd_valid_q        <= 1'b0;
      rd_data_q         <= '0;
      wr_cmd_accepted_q <= 1'b0;
      wr_valid_q        <= 1'b0;
      mem_req_q         <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= '0;
      mem_wdata_q       <= '0;
    end else begin
      rd_cmd_accepted_q <= 1'b0;
      wr_cmd_accepted_q <= 1'b0;
      rd_valid_q        <= 1'b0;
      wr_valid_q        <= 1'b0;
      mem_req_q         <= 1'b0;
      unique case (state_q)
        Idle: begin
          if (grant_any_d) begin
            mem_req_q       <= 1'b1;
            mem_we_q        <= ~grant_rd_d;
            last_grant_wr_q <= ~grant_rd_d;
            if (grant_rd_d) begin
              mem_addr_q        <= rd_addr_i;
              rd_cmd_accepted_q <= 1'b1;
              state_q           <= WaitRd;
            end else begin
              mem_addr_q        <= wr_addr_i;
              mem_wdata_q       <= wr_data_i;
              wr_cmd_accepted_q <= 1'b1;
              state_q           <= WaitWr;
            end
          end
        end
        WaitRd: begin
          if (mem_valid_i) begin
            rd_data_q  <= mem_rdata_i;
            rd_valid_q <= 1'b1;
            state_q    <= Idle;
          end
        end
        WaitWr: begin
          if (mem_valid_i) begin
            wr_valid_q <= 1'b1;
            state_q    <= Idle;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign rd_cmd_accepted_o = rd_cmd_accepted_q;
  assign rd_valid_o        = rd_valid_q;
  assign rd_data_o         = rd_data_q;
  assign wr_cmd_accepted_o = wr_cmd_accepted_q;
  assign wr_valid_o        = wr_valid_q;
  assign mem_req_o         = mem_req_q;
  assign mem_we_o          = mem_we_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_wdata_o       = mem_wdata_q;

endmodule

// File: tb/tb_snow64_memory_bus_guard.sv
// Directed self-checking bench for snow64_memory_bus_guard: reset, single read and
// write, round-robin contention, memory busy back-pressure and reset mid-transaction.
module tb_snow64_memory_bus_guard;

  localparam int AW = 64;
  localparam int DW = 256;

  logic          clk;
  logic          rst;
  logic          rdReq;
  logic [AW-1:0] rdAddr;
  logic          rdCmdAccepted;
  logic          rdValid;
  logic [DW-1:0] rdData;
  logic          wrReq;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic          wrCmdAccepted;
  logic          wrValid;
  logic          memReq;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic          memBusy;
  logic          memValid;
  logic [DW-1:0] memRdata;

  int checkCount = 0;
  int passCount  = 0;
  int rdAccCount = 0;
  int wrAccCount = 0;
  int rdValCount = 0;
  int wrValCount = 0;
  int memReqCount = 0;

  logic [DW-1:0] patA5;
  logic [DW-1:0] pat3C;
  logic [DW-1:0] patFF;

  snow64_memory_bus_guard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .rd_req_i         (rdReq),
    .rd_addr_i        (rdAddr),
    .rd_cmd_accepted_o(rdCmdAccepted),
    .rd_valid_o       (rdValid),
    .rd_data_o        (rdData),
    .wr_req_i         (wrReq),
    .wr_addr_i        (wrAddr),
    .wr_data_i        (wrData),
    .wr_cmd_accepted_o(wrCmdAccepted),
    .wr_valid_o       (wrValid),
    .mem_req_o        (memReq),
    .mem_we_o         (memWe),
    .mem_addr_o       (memAddr),
    .mem_wdata_o      (memWdata),
    .mem_busy_i       (memBusy),
    .mem_valid_i      (memValid),
    .mem_rdata_i      (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rdCmdAccepted) rdAccCount++;
      if (wrCmdAccepted) wrAccCount++;
      if (rdValid)       rdValCount++;
      if (wrValid)       wrValCount++;
      if (memReq)        memReqCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic rq, input logic [AW-1:0] ra,
                               input logic wq, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic busy);
    rdReq   = rq;
    rdAddr  = ra;
    wrReq   = wq;
    wrAddr  = wa;
    wrData  = wd;
    memBusy = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until mem_req is seen, bounded so a dead DUT still reaches the summary.
  task automatic waitMemReq(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!memReq && n < 10);
    checkOutput(tag, memReq, 1'b1);
  endtask

  initial begin
    patA5 = {32{8'hA5}};
    pat3C = {32{8'h3C}};
    patFF = {32{8'hFF}};
    rst = 1'b1;
    memValid = 1'b0;
    memRdata = '0;
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);

    // Reset held three cycles
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("rstMemReq",   memReq, 1'b0);
    checkOutput("rstMemWe",    memWe, 1'b0);
    checkOutput("rstRdAcc",    rdCmdAccepted, 1'b0);
    checkOutput("rstWrAcc",    wrCmdAccepted, 1'b0);
    checkOutput("rstRdValid",  rdValid, 1'b0);
    checkOutput("rstWrValid",  wrValid, 1'b0);
    checkOutput("rstRdData",   rdData, '0);
    checkOutput("rstMemAddr",  memAddr, '0);
    checkOutput("rstMemWdata", memWdata, '0);

    // Single read, data returned two cycles after mem_req
    applyStimulus(1'b1, 64'h1000, 1'b0, '0, '0, 1'b0);
    tick();
    checkOutput("rdMemReq",  memReq, 1'b1);
    checkOutput("rdAcc",     rdCmdAccepted, 1'b1);
    checkOutput("rdMemWe",   memWe, 1'b0);
    checkOutput("rdMemAddr", memAddr, 64'h1000);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    checkOutput("rdAccPulse", rdCmdAccepted, 1'b0);
    checkOutput("rdReqPulse", memReq, 1'b0);
    tick();
    memValid = 1'b1;
    memRdata = patA5;
    checkOutput("rdValidEarly", rdValid, 1'b0);
    tick();
    memValid = 1'b0;
    memRdata = '0;
    checkOutput("rdValid",     rdValid, 1'b1);
    checkOutput("rdData",      rdData, patA5);
    checkOutput("rdAddrHold",  memAddr, 64'h1000);
    tick();
    checkOutput("rdValidPulse", rdValid, 1'b0);
    checkOutput("rdAccTotal",   rdAccCount, 1);
    checkOutput("rdWrAccQuiet", wrAccCount, 0);
    checkOutput("rdWrValQuiet", wrValCount, 0);

    // Single write at minimum latency
    applyStimulus(1'b0, '0, 1'b1, 64'h2020, 256'h1234, 1'b0);
    tick();
    checkOutput("wrMemReq",   memReq, 1'b1);
    checkOutput("wrAcc",      wrCmdAccepted, 1'b1);
    checkOutput("wrRdAcc",    rdCmdAccepted, 1'b0);
    checkOutput("wrMemWe",    memWe, 1'b1);
    checkOutput("wrMemAddr",  memAddr, 64'h2020);
    checkOutput("wrMemWdata", memWdata, 256'h1234);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    memValid = 1'b1;
    tick();
    memValid = 1'b0;
    checkOutput("wrValid",   wrValid, 1'b1);
    checkOutput("wrRdValid", rdValid, 1'b0);
    tick();
    checkOutput("wrValidPulse", wrValid, 1'b0);

    // Contention: both held high, expect read, write, read, write
    applyStimulus(1'b1, 64'h4000, 1'b1, 64'h5000, 256'h77, 1'b0);
    for (int i = 0; i < 4; i++) begin
      waitMemReq($sformatf("cont%0dReq", i));
      checkOutput($sformatf("cont%0dWe", i), memWe, (i % 2 == 1));
      checkOutput($sformatf("cont%0dAddr", i), memAddr, (i % 2 == 1) ? 64'h5000 : 64'h4000);
      tick();
      memValid = 1'b1;
      memRdata = pat3C;
      tick();
      memValid = 1'b0;
      checkOutput($sformatf("cont%0dRdValid", i), rdValid, (i % 2 == 0));
      checkOutput($sformatf("cont%0dWrValid", i), wrValid, (i % 2 == 1));
    end
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    checkOutput("contRdData", rdData, pat3C);
    tick();

    // Memory busy for five cycles holds off the read
    applyStimulus(1'b1, 64'h6000, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("busy%0dMemReq", i), memReq, 1'b0);
      checkOutput($sformatf("busy%0dAcc", i), rdCmdAccepted, 1'b0);
    end
    memBusy = 1'b0;
    tick();
    checkOutput("busyGrant",    memReq, 1'b1);
    checkOutput("busyGrantAcc", rdCmdAccepted, 1'b1);
    checkOutput("busyGrantAddr", memAddr, 64'h6000);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    memValid = 1'b1;
    memRdata = patFF;
    tick();
    memValid = 1'b0;
    checkOutput("busyRdValid", rdValid, 1'b1);
    checkOutput("busyRdData",  rdData, patFF);
    tick();

    // Reset while waiting for read data
    applyStimulus(1'b1, 64'h3000, 1'b0, '0, '0, 1'b0);
    tick();
    checkOutput("midReq", memReq, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midAsyncAddr", memAddr, '0);
    checkOutput("midAsyncData", rdData, '0);
    tick();
    rst = 1'b0;
    tick();
    memValid = 1'b1;
    memRdata = patA5;
    tick();
    memValid = 1'b0;
    checkOutput("midNoRdValid", rdValid, 1'b0);
    checkOutput("midRdData",    rdData, '0);
    tick();
    checkOutput("midNoRdValid2", rdValid, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 64'h8000, 256'h99, 1'b0);
    tick();
    checkOutput("midIdleGrant", wrCmdAccepted, 1'b1);
    checkOutput("midIdleWe",    memWe, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    memValid = 1'b1;
    tick();
    memValid = 1'b0;
    checkOutput("midWrValid", wrValid, 1'b1);
    tick();

    checkOutput("totRdAcc",  rdAccCount, 5);
    checkOutput("totWrAcc",  wrAccCount, 4);
    checkOutput("totRdVal",  rdValCount, 4);
    checkOutput("totWrVal",  wrValCount, 4);
    checkOutput("totMemReq", memReqCount, 9);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
